// File: rtl/systolic_tile_scheduler.sv
// Job-level tile sequencer for the systolic array.
// Walks an M x N output in tiles of at most TILE x TILE. For each tile it issues the array instruction, both read streams and the result write, then counts result beats.
module systolic_tile_scheduler #(
  parameter int TILE       = 31,
  parameter int BEAT_BYTES = 32
) (
  input  logic        CLOCK,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_m,
  input  logic [15:0] cmd_n,
  input  logic [31:0] cmd_row_base,
  input  logic [31:0] cmd_col_base,
  input  logic [31:0] cmd_out_base,
  input  logic        abort,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic        rdr_valid,
  input  logic        rdr_ready,
  output logic [31:0] rdr_addr,
  output logic [5:0]  rdr_len,
  output logic        rdc_valid,
  input  logic        rdc_ready,
  output logic [31:0] rdc_addr,
  output logic [5:0]  rdc_len,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [5:0]  wr_len,
  input  logic        res_valid,
  input  logic        res_ready,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [31:0] tile_count,
  output logic [2:0]  dbg_state
);

  // Handshakes: a transfer occurs on the rising CLOCK edge where valid && ready
  // are both high; once valid is raised it and its data hold until that edge.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WCMD  = 3'd2,
    S_DRAIN = 3'd3,
    S_NEXT  = 3'd4
  } state_t;

  localparam logic [15:0] TILE16     = 16'(TILE);
  localparam logic [31:0] BEAT32     = 32'(BEAT_BYTES);
  localparam logic [31:0] TILE_BYTES = 32'(TILE * BEAT_BYTES);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_m;
  logic [15:0] r_n;
  logic [31:0] r_row_base;
  logic [31:0] r_col_base;
  logic [31:0] r_out_base;
  logic [15:0] r_row_off;
  logic [15:0] r_col_off;
  logic [31:0] r_tile_count;
  logic        r_abort_flag;
  logic        r_empty;
  logic        r_instr_pend;
  logic        r_rdr_pend;
  logic        r_rdc_pend;
  logic [5:0]  r_beat_cnt;
  logic        r_done;
  logic        r_aborted;

  logic [15:0] w_rows_rem;
  logic [15:0] w_cols_rem;
  logic [4:0]  w_rows5;
  logic [4:0]  w_cols5;
  logic        w_last_row;
  logic        w_last_col;
  logic        w_last_tile;
  logic        w_beat;
  logic        w_counting;
  logic [5:0]  w_cnt_nxt;
  logic        w_iss_all;
  logic        w_cmd_zero;
  logic        w_abort_any;
  logic        w_accept;
  logic        w_tile_next;
  logic        w_done_set;
  logic        w_abort_set;

  // row/col offsets hold mi*TILE and ni*TILE so no multiply by the tile index is needed
  assign w_rows_rem  = r_m - r_row_off;
  assign w_cols_rem  = r_n - r_col_off;
  assign w_rows5     = (w_rows_rem > TILE16) ? 5'(TILE) : w_rows_rem[4:0];
  assign w_cols5     = (w_cols_rem > TILE16) ? 5'(TILE) : w_cols_rem[4:0];
  assign w_last_row  = (w_rows_rem <= TILE16);
  assign w_last_col  = (w_cols_rem <= TILE16);
  assign w_last_tile = w_last_row && w_last_col;

  assign w_beat      = res_valid && res_ready;
  assign w_counting  = (r_state == S_ISSUE) || (r_state == S_WCMD) || (r_state == S_DRAIN);
  assign w_cnt_nxt   = r_beat_cnt + {5'b0, w_beat};
  assign w_iss_all   = (!r_instr_pend || instr_ready) &&
                       (!r_rdr_pend   || rdr_ready)   &&
                       (!r_rdc_pend   || rdc_ready);
  assign w_cmd_zero  = (cmd_m == 16'd0) || (cmd_n == 16'd0);
  assign w_abort_any = r_abort_flag || abort;

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_tile_next = 1'b0;
    w_done_set  = 1'b0;
    w_abort_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_cmd_zero ? S_NEXT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_iss_all) w_state_nxt = S_WCMD;
      end
      S_WCMD: begin
        if (wr_ready) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_cnt_nxt >= {1'b0, w_cols5}) w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (r_empty || w_last_tile) begin
          w_done_set  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_abort_any) begin
          w_abort_set = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tile_next = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      r_m          <= '0;
      r_n          <= '0;
      r_row_base   <= '0;
      r_col_base   <= '0;
      r_out_base   <= '0;
      r_row_off    <= '0;
      r_col_off    <= '0;
      r_tile_count <= '0;
      r_abort_flag <= 1'b0;
      r_empty      <= 1'b0;
      r_instr_pend <= 1'b0;
      r_rdr_pend   <= 1'b0;
      r_rdc_pend   <= 1'b0;
      r_beat_cnt   <= '0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_done    <= w_done_set;
      r_aborted <= w_abort_set;
      if (w_accept) begin
        r_m          <= cmd_m;
        r_n          <= cmd_n;
        r_row_base   <= cmd_row_base;
        r_col_base   <= cmd_col_base;
        r_out_base   <= cmd_out_base;
        r_row_off    <= '0;
        r_col_off    <= '0;
        r_tile_count <= '0;
        r_abort_flag <= 1'b0;
        r_empty      <= w_cmd_zero;
        r_instr_pend <= !w_cmd_zero;
        r_rdr_pend   <= !w_cmd_zero;
        r_rdc_pend   <= !w_cmd_zero;
        r_beat_cnt   <= '0;
      end else begin
        if ((r_state != S_IDLE) && abort) r_abort_flag <= 1'b1;
        r_instr_pend <= r_instr_pend && !instr_ready;
        r_rdr_pend   <= r_rdr_pend   && !rdr_ready;
        r_rdc_pend   <= r_rdc_pend   && !rdc_ready;
        // early beats count toward the tile already issued; saturate rather than wrap
        if (w_counting && w_beat && (r_beat_cnt != 6'h3F)) r_beat_cnt <= r_beat_cnt + 6'd1;
        if (r_state == S_NEXT) begin
          r_beat_cnt <= '0;
          if (!r_empty) begin
            r_tile_count <= r_tile_count + 32'd1;
            if (w_last_col) begin
              r_col_off <= '0;
              r_row_off <= r_row_off + TILE16;
            end else begin
              r_col_off <= r_col_off + TILE16;
            end
          end
          if (w_tile_next) begin
            r_instr_pend <= 1'b1;
            r_rdr_pend   <= 1'b1;
            r_rdc_pend   <= 1'b1;
          end
        end
      end
    end
  end

  // data fields are forced to zero whenever their valid is low
  assign cmd_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign instr_valid = r_instr_pend;
  assign instr_data  = r_instr_pend ? {22'b0, w_rows5, w_cols5} : '0;
  assign rdr_valid   = r_rdr_pend;
  assign rdr_addr    = r_rdr_pend ? (r_row_base + ({16'b0, r_row_off} * BEAT32)) : '0;
  assign rdr_len     = r_rdr_pend ? {1'b0, w_rows5} : '0;
  assign rdc_valid   = r_rdc_pend;
  assign rdc_addr    = r_rdc_pend ? (r_col_base + ({16'b0, r_col_off} * BEAT32)) : '0;
  assign rdc_len     = r_rdc_pend ? {1'b0, w_cols5} : '0;
  assign wr_valid    = (r_state == S_WCMD);
  assign wr_addr     = wr_valid ? (r_out_base + (r_tile_count * TILE_BYTES)) : '0;
  assign wr_len      = wr_valid ? {1'b0, w_cols5} : '0;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign tile_count  = r_tile_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Directed bench for systolic_tile_scheduler: single tile, 6-tile walk,
// staggered readies, empty job, abort at a tile boundary and mid-job reset.
module tb_systolic_tile_scheduler;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WCMD  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;

  logic        CLOCK = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_m = '0;
  logic [15:0] cmd_n = '0;
  logic [31:0] cmd_row_base = '0;
  logic [31:0] cmd_col_base = '0;
  logic [31:0] cmd_out_base = '0;
  logic        abort = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr_data;
  logic        rdr_valid;
  logic        rdr_ready = 1'b1;
  logic [31:0] rdr_addr;
  logic [5:0]  rdr_len;
  logic        rdc_valid;
  logic        rdc_ready = 1'b1;
  logic [31:0] rdc_addr;
  logic [5:0]  rdc_len;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [31:0] wr_addr;
  logic [5:0]  wr_len;
  logic        res_valid = 1'b0;
  logic        res_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [31:0] tile_count;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  systolic_tile_scheduler #(.TILE(31), .BEAT_BYTES(32)) dut (
    .CLOCK(CLOCK), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_m(cmd_m), .cmd_n(cmd_n),
    .cmd_row_base(cmd_row_base), .cmd_col_base(cmd_col_base), .cmd_out_base(cmd_out_base),
    .abort(abort),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .rdr_valid(rdr_valid), .rdr_ready(rdr_ready), .rdr_addr(rdr_addr), .rdr_len(rdr_len),
    .rdc_valid(rdc_valid), .rdc_ready(rdc_ready), .rdc_addr(rdc_addr), .rdc_len(rdc_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_len(wr_len),
    .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .done(done), .aborted(aborted),
    .tile_count(tile_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLOCK = ~CLOCK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver and checking tasks; inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(negedge CLOCK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int k;
    k = 0;
    while (dbg_state !== s && k < budget) begin
      step();
      k++;
    end
    check({tag, "_wait_state"}, {29'b0, dbg_state}, {29'b0, s});
  endtask

  task automatic send_cmd(input logic [15:0] m, input logic [15:0] n,
                          input logic [31:0] rb, input logic [31:0] cb, input logic [31:0] ob);
    wait_state("cmd_idle", S_IDLE, 50);
    cmd_m        = m;
    cmd_n        = n;
    cmd_row_base = rb;
    cmd_col_base = cb;
    cmd_out_base = ob;
    cmd_valid    = 1'b1;
    check("cmd_ready", {31'b0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  // one tile with all downstream readies high; ends on the NEXT-state cycle
  task automatic do_tile(input string tg, input logic [31:0] e_instr, input logic [31:0] e_rdr,
                         input logic [31:0] e_rdc, input logic [31:0] e_wr, input int e_cols,
                         input bit pulse_abort);
    wait_state(tg, S_ISSUE, 20);
    check({tg, "_instr"}, instr_data, e_instr);
    check({tg, "_rdr_addr"}, rdr_addr, e_rdr);
    check({tg, "_rdc_addr"}, rdc_addr, e_rdc);
    check({tg, "_rdr_len"}, {26'b0, rdr_len}, {27'b0, e_instr[9:5]});
    check({tg, "_rdc_len"}, {26'b0, rdc_len}, e_cols);
    step();
    check({tg, "_wr_valid"}, {31'b0, wr_valid}, 32'd1);
    check({tg, "_wr_addr"}, wr_addr, e_wr);
    check({tg, "_wr_len"}, {26'b0, wr_len}, e_cols);
    step();
    res_valid = 1'b1;
    abort     = pulse_abort;
    for (int i = 0; i < e_cols; i++) begin
      if (i == e_cols - 1) check({tg, "_drain_hold"}, {29'b0, dbg_state}, {29'b0, S_DRAIN});
      step();
      abort = 1'b0;
    end
    res_valid = 1'b0;
    check({tg, "_next"}, {29'b0, dbg_state}, {29'b0, S_NEXT});
  endtask

  logic [31:0] t_instr [6] = '{32'h3FF, 32'h3FF, 32'h3E8, 32'h13F, 32'h13F, 32'h128};
  logic [31:0] t_rdr   [6] = '{32'h1000, 32'h1000, 32'h1000, 32'h13E0, 32'h13E0, 32'h13E0};
  logic [31:0] t_rdc   [6] = '{32'h2000, 32'h23E0, 32'h27C0, 32'h2000, 32'h23E0, 32'h27C0};
  logic [31:0] t_wr    [6] = '{32'h8000, 32'h83E0, 32'h87C0, 32'h8BA0, 32'h8F80, 32'h9360};
  int          t_cols  [6] = '{31, 31, 8, 31, 31, 8};

  initial begin
    // reset state
    step();
    step();
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_valids", {28'b0, instr_valid, rdr_valid, rdc_valid, wr_valid}, 32'd0);
    check("rst_status", {29'b0, busy, done, aborted}, 32'd0);
    check("rst_tile_count", tile_count, 32'd0);
    check("rst_data", instr_data | rdr_addr | rdc_addr | wr_addr, 32'd0);
    check("rst_lens", {14'b0, rdr_len, rdc_len, wr_len}, 32'd0);
    reset = 1'b0;
    step();

    // single 31x31 tile
    send_cmd(16'd31, 16'd31, 32'h100, 32'h200, 32'h300);
    check("t1_busy", {31'b0, busy}, 32'd1);
    check("t1_cmd_ready_low", {31'b0, cmd_ready}, 32'd0);
    check("t1_valids", {29'b0, instr_valid, rdr_valid, rdc_valid}, 32'd7);
    do_tile("t1", 32'h3FF, 32'h100, 32'h200, 32'h300, 31, 1'b0);
    check("t1_done_early", {31'b0, done}, 32'd0);
    step();
    check("t1_done", {31'b0, done}, 32'd1);
    check("t1_busy_off", {31'b0, busy}, 32'd0);
    check("t1_tile_count", tile_count, 32'd1);
    step();
    check("t1_done_pulse", {31'b0, done}, 32'd0);

    // 40x70 job: six tiles, ni inner
    send_cmd(16'd40, 16'd70, 32'h1000, 32'h2000, 32'h8000);
    for (int i = 0; i < 6; i++) begin
      do_tile($sformatf("t2_tile%0d", i), t_instr[i], t_rdr[i], t_rdc[i], t_wr[i], t_cols[i], 1'b0);
      step();
      check("t2_tile_count", tile_count, i + 1);
      if (i == 5) check("t2_done", {31'b0, done}, 32'd1);
      else check("t2_back_to_issue", {29'b0, dbg_state}, {29'b0, S_ISSUE});
    end
    check("t2_aborted_low", {31'b0, aborted}, 32'd0);

    // abort during the second tile's drain
    send_cmd(16'd40, 16'd70, 32'h1000, 32'h2000, 32'h8000);
    do_tile("ab_tile0", t_instr[0], t_rdr[0], t_rdc[0], t_wr[0], t_cols[0], 1'b0);
    step();
    do_tile("ab_tile1", t_instr[1], t_rdr[1], t_rdc[1], t_wr[1], t_cols[1], 1'b1);
    check("ab_aborted_early", {31'b0, aborted}, 32'd0);
    step();
    check("ab_aborted", {31'b0, aborted}, 32'd1);
    check("ab_done_low", {31'b0, done}, 32'd0);
    check("ab_tile_count", tile_count, 32'd2);
    check("ab_busy_off", {31'b0, busy}, 32'd0);
    step();
    check("ab_aborted_pulse", {31'b0, aborted}, 32'd0);

    // next command after abort runs normally
    send_cmd(16'd4, 16'd4, 32'h0, 32'h0, 32'h100);
    do_tile("post", 32'h84, 32'h0, 32'h0, 32'h100, 4, 1'b0);
    step();
    check("post_done", {31'b0, done}, 32'd1);
    check("post_tile_count", tile_count, 32'd1);

    // staggered readies: rdr on ISSUE cycle 1, instr on 3, rdc on 5; wr held 2 cycles
    instr_ready = 1'b0;
    rdr_ready   = 1'b0;
    rdc_ready   = 1'b0;
    wr_ready    = 1'b0;
    send_cmd(16'd8, 16'd8, 32'h100, 32'h200, 32'h4000);
    for (int k = 1; k <= 5; k++) begin
      check("st_issue", {29'b0, dbg_state}, {29'b0, S_ISSUE});
      check("st_instr_valid", {31'b0, instr_valid}, (k <= 3) ? 32'd1 : 32'd0);
      check("st_rdr_valid", {31'b0, rdr_valid}, (k <= 1) ? 32'd1 : 32'd0);
      check("st_rdc_valid", {31'b0, rdc_valid}, 32'd1);
      if (k <= 3) check("st_instr_data", instr_data, 32'h108);
      check("st_rdc_addr", rdc_addr, 32'h200);
      check("st_rdc_len", {26'b0, rdc_len}, 32'd8);
      rdr_ready   = (k == 1);
      instr_ready = (k == 3);
      rdc_ready   = (k == 5);
      step();
    end
    instr_ready = 1'b0;
    rdr_ready   = 1'b0;
    rdc_ready   = 1'b0;
    check("st_wcmd", {29'b0, dbg_state}, {29'b0, S_WCMD});
    check("st_issue_valids_off", {29'b0, instr_valid, rdr_valid, rdc_valid}, 32'd0);
    check("st_wr_addr", wr_addr, 32'h4000);
    step();
    check("st_wr_hold", {31'b0, wr_valid}, 32'd1);
    check("st_wr_addr_hold", wr_addr, 32'h4000);
    check("st_wr_len_hold", {26'b0, wr_len}, 32'd8);
    wr_ready = 1'b1;
    step();
    check("st_drain", {29'b0, dbg_state}, {29'b0, S_DRAIN});
    res_valid = 1'b1;
    repeat (8) step();
    res_valid = 1'b0;
    check("st_next", {29'b0, dbg_state}, {29'b0, S_NEXT});
    step();
    check("st_done", {31'b0, done}, 32'd1);
    instr_ready = 1'b1;
    rdr_ready   = 1'b1;
    rdc_ready   = 1'b1;

    // empty job
    send_cmd(16'd0, 16'd5, 32'h0, 32'h0, 32'h0);
    check("z_busy", {31'b0, busy}, 32'd1);
    check("z_state", {29'b0, dbg_state}, {29'b0, S_NEXT});
    check("z_valids", {28'b0, instr_valid, rdr_valid, rdc_valid, wr_valid}, 32'd0);
    check("z_done_early", {31'b0, done}, 32'd0);
    step();
    check("z_done", {31'b0, done}, 32'd1);
    check("z_busy_off", {31'b0, busy}, 32'd0);
    check("z_valids2", {28'b0, instr_valid, rdr_valid, rdc_valid, wr_valid}, 32'd0);
    check("z_tile_count", tile_count, 32'd0);
    step();
    check("z_done_pulse", {31'b0, done}, 32'd0);

    // reset during ISSUE with valids high
    instr_ready = 1'b0;
    rdr_ready   = 1'b0;
    rdc_ready   = 1'b0;
    send_cmd(16'd31, 16'd31, 32'h500, 32'h600, 32'h700);
    check("mr_valids_high", {29'b0, instr_valid, rdr_valid, rdc_valid}, 32'd7);
    #2 reset = 1'b1;
    #1;
    check("mr_valids", {28'b0, instr_valid, rdr_valid, rdc_valid, wr_valid}, 32'd0);
    check("mr_data", instr_data | rdr_addr | rdc_addr, 32'd0);
    check("mr_status", {29'b0, busy, done, aborted}, 32'd0);
    check("mr_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    step();
    reset = 1'b0;
    instr_ready = 1'b1;
    rdr_ready   = 1'b1;
    rdc_ready   = 1'b1;
    step();
    check("mr_idle", {29'b0, dbg_state}, {29'b0, S_IDLE});
    check("mr_cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
    check("mr_no_pulse", {30'b0, done, aborted}, 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
